// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: port indices, one-hot direction codes and
// the round-robin pointer wrap used by the switch allocator.
package noc_pkg;

    localparam int NPORT = 5;

    typedef logic [2:0] port_idx_t;

    localparam port_idx_t P_N = 3'd0;
    localparam port_idx_t P_E = 3'd1;
    localparam port_idx_t P_W = 3'd2;
    localparam port_idx_t P_S = 3'd3;
    localparam port_idx_t P_L = 3'd4;

    localparam logic [NPORT-1:0] DIR_N = 5'b00001;
    localparam logic [NPORT-1:0] DIR_E = 5'b00010;
    localparam logic [NPORT-1:0] DIR_W = 5'b00100;
    localparam logic [NPORT-1:0] DIR_S = 5'b01000;
    localparam logic [NPORT-1:0] DIR_L = 5'b10000;

    // Next port in the N->E->W->S->L->N ring.
    function automatic port_idx_t wrap_inc(input port_idx_t p);
        return (p == P_L) ? P_N : port_idx_t'(p + 3'd1);
    endfunction

endpackage

// File: rtl/rr_arb5.sv
// Five-input round-robin arbiter for one output port: combinational one-hot
// grant, registered pointer that moves past the winner.
module rr_arb5
    import noc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req_i,
    input  logic             en_i,
    output logic [NPORT-1:0] gnt_o
);

    port_idx_t ptr_q, ptr_d;
    port_idx_t idx;
    logic      found;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int k = 0; k < NPORT; k++) begin
            if (!found && en_i && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                ptr_d      = wrap_inc(idx);
                found      = 1'b1;
            end
            idx = wrap_inc(idx);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= P_N;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sw_alloc_xbar.sv
// Switch allocator and crossbar: decodes one-hot routes into per-output
// requests, arbitrates, and registers the winning flit in each output slot.
module sw_alloc_xbar
    import noc_pkg::*;
#(
    parameter int DATASIZE = 30
) (
    input  logic                sa_clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] N_data_in,
    input  logic [DATASIZE-1:0] E_data_in,
    input  logic [DATASIZE-1:0] W_data_in,
    input  logic [DATASIZE-1:0] S_data_in,
    input  logic [DATASIZE-1:0] L_data_in,
    input  logic [NPORT-1:0]    N_dir_in,
    input  logic [NPORT-1:0]    E_dir_in,
    input  logic [NPORT-1:0]    W_dir_in,
    input  logic [NPORT-1:0]    S_dir_in,
    input  logic [NPORT-1:0]    L_dir_in,
    input  logic                N_valid_in,
    input  logic                E_valid_in,
    input  logic                W_valid_in,
    input  logic                S_valid_in,
    input  logic                L_valid_in,
    output logic                rc_ready_N,
    output logic                rc_ready_E,
    output logic                rc_ready_W,
    output logic                rc_ready_S,
    output logic                rc_ready_L,
    output logic [DATASIZE-1:0] N_data_out,
    output logic [DATASIZE-1:0] E_data_out,
    output logic [DATASIZE-1:0] W_data_out,
    output logic [DATASIZE-1:0] S_data_out,
    output logic [DATASIZE-1:0] L_data_out,
    output logic                N_valid_out,
    output logic                E_valid_out,
    output logic                W_valid_out,
    output logic                S_valid_out,
    output logic                L_valid_out,
    input  logic                N_ready_in,
    input  logic                E_ready_in,
    input  logic                W_ready_in,
    input  logic                S_ready_in,
    input  logic                L_ready_in,
    output logic                err_dir
);

    logic [DATASIZE-1:0] data_in    [NPORT];
    logic [NPORT-1:0]    dir_in     [NPORT];
    logic [NPORT-1:0]    req        [NPORT];   // req[o][i]: input i wants output o
    logic [NPORT-1:0]    gnt        [NPORT];
    logic [DATASIZE-1:0] data_out_q [NPORT];
    logic [DATASIZE-1:0] data_out_d [NPORT];
    logic [NPORT-1:0]    valid_in, ready_in, dir_ok, drop, out_free, rc_ready;
    logic [NPORT-1:0]    valid_out_q, valid_out_d;
    logic                err_dir_q;

    assign data_in  = '{N_data_in, E_data_in, W_data_in, S_data_in, L_data_in};
    assign dir_in   = '{N_dir_in, E_dir_in, W_dir_in, S_dir_in, L_dir_in};
    assign valid_in = {L_valid_in, S_valid_in, W_valid_in, E_valid_in, N_valid_in};
    assign ready_in = {L_ready_in, S_ready_in, W_ready_in, E_ready_in, N_ready_in};

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            dir_ok[i] = $onehot(dir_in[i]);
            drop[i]   = !rst && valid_in[i] && !dir_ok[i];
        end
        for (int o = 0; o < NPORT; o++) begin
            out_free[o] = !valid_out_q[o] || ready_in[o];
            for (int i = 0; i < NPORT; i++)
                req[o][i] = valid_in[i] && dir_ok[i] && dir_in[i][o];
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_arb
        rr_arb5 u_arb (
            .clk   (sa_clk),
            .rst   (rst),
            .req_i (req[o]),
            .en_i  (out_free[o] && !rst),
            .gnt_o (gnt[o])
        );
    end

    // Grants are one-hot per output and each input targets one output, so the
    // OR over outputs is exactly "my output picked me".
    always_comb begin
        rc_ready = drop;
        for (int o = 0; o < NPORT; o++) begin
            rc_ready       = rc_ready | gnt[o];
            valid_out_d[o] = valid_out_q[o] && !ready_in[o];
            data_out_d[o]  = data_out_q[o];
            for (int i = 0; i < NPORT; i++) begin
                if (gnt[o][i]) begin
                    valid_out_d[o] = 1'b1;
                    data_out_d[o]  = data_in[i];
                end
            end
        end
    end

    always_ff @(posedge sa_clk) begin
        if (rst) begin
            valid_out_q <= '0;
            err_dir_q   <= 1'b0;
            for (int o = 0; o < NPORT; o++) data_out_q[o] <= '0;
        end else begin
            valid_out_q <= valid_out_d;
            err_dir_q   <= |drop;
            data_out_q  <= data_out_d;
        end
    end

    assign {rc_ready_L, rc_ready_S, rc_ready_W, rc_ready_E, rc_ready_N} = rc_ready;
    assign {L_valid_out, S_valid_out, W_valid_out, E_valid_out, N_valid_out} = valid_out_q;
    assign N_data_out = data_out_q[P_N];
    assign E_data_out = data_out_q[P_E];
    assign W_data_out = data_out_q[P_W];
    assign S_data_out = data_out_q[P_S];
    assign L_data_out = data_out_q[P_L];
    assign err_dir    = err_dir_q;

endmodule

// File: tb/tb_sw_alloc_xbar.sv
// Directed bench for sw_alloc_xbar: hand-computed expectations for routing,
// round-robin order, back-pressure, malformed routes and reset.
module tb_sw_alloc_xbar;
    import noc_pkg::*;

    logic        sa_clk = 1'b0;
    logic        rst;
    logic [29:0] data_in  [NPORT];
    logic [4:0]  dir_in   [NPORT];
    logic [29:0] data_out [NPORT];
    logic [4:0]  valid_in, ready_in, rc_ready, valid_out;
    logic        err_dir;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 sa_clk = ~sa_clk;

    sw_alloc_xbar #(.DATASIZE(30)) dut (
        .sa_clk      (sa_clk),
        .rst         (rst),
        .N_data_in   (data_in[0]), .E_data_in (data_in[1]), .W_data_in (data_in[2]),
        .S_data_in   (data_in[3]), .L_data_in (data_in[4]),
        .N_dir_in    (dir_in[0]),  .E_dir_in  (dir_in[1]),  .W_dir_in  (dir_in[2]),
        .S_dir_in    (dir_in[3]),  .L_dir_in  (dir_in[4]),
        .N_valid_in  (valid_in[0]), .E_valid_in (valid_in[1]), .W_valid_in (valid_in[2]),
        .S_valid_in  (valid_in[3]), .L_valid_in (valid_in[4]),
        .rc_ready_N  (rc_ready[0]), .rc_ready_E (rc_ready[1]), .rc_ready_W (rc_ready[2]),
        .rc_ready_S  (rc_ready[3]), .rc_ready_L (rc_ready[4]),
        .N_data_out  (data_out[0]), .E_data_out (data_out[1]), .W_data_out (data_out[2]),
        .S_data_out  (data_out[3]), .L_data_out (data_out[4]),
        .N_valid_out (valid_out[0]), .E_valid_out (valid_out[1]), .W_valid_out (valid_out[2]),
        .S_valid_out (valid_out[3]), .L_valid_out (valid_out[4]),
        .N_ready_in  (ready_in[0]), .E_ready_in (ready_in[1]), .W_ready_in (ready_in[2]),
        .S_ready_in  (ready_in[3]), .L_ready_in (ready_in[4]),
        .err_dir     (err_dir)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sa_clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_in = '0;
        for (int i = 0; i < NPORT; i++) begin
            data_in[i] = '0;
            dir_in[i]  = '0;
        end
    endtask

    task automatic send(input int i, input logic [4:0] dir, input logic [29:0] data);
        valid_in[i] = 1'b1;
        dir_in[i]   = dir;
        data_in[i]  = data;
    endtask

    logic [4:0]  exp_rc   [4];
    logic [29:0] exp_data [4];

    initial begin
        rst      = 1'b1;
        ready_in = '0;
        clear_inputs();
        send(P_N, DIR_E, 30'h111);

        // Reset state
        tick();
        tick();
        check("rst_valid_out", 32'(valid_out), 32'h0);
        check("rst_err_dir", 32'(err_dir), 32'h0);
        check("rst_rc_ready", 32'(rc_ready), 32'h0);
        for (int o = 0; o < NPORT; o++) check($sformatf("rst_data_out%0d", o), 32'(data_out[o]), 32'h0);
        rst = 1'b0;
        clear_inputs();
        tick();

        // 1: single flit N -> E
        ready_in[P_E] = 1'b1;
        send(P_N, DIR_E, 30'h1234567);
        #1;
        check("t1_rc_ready", 32'(rc_ready), 32'b00001);
        tick();
        clear_inputs();
        check("t1_valid_out", 32'(valid_out), 32'b00010);
        check("t1_E_data", 32'(data_out[P_E]), 32'h1234567);
        tick();
        check("t1_drained", 32'(valid_out), 32'h0);

        // 2: N, W, L contend for S; round robin N, W, L, N with no bubble
        ready_in = '1;
        send(P_N, DIR_S, 30'h100);
        send(P_W, DIR_S, 30'h300);
        send(P_L, DIR_S, 30'h500);
        exp_rc   = '{5'b00001, 5'b00100, 5'b10000, 5'b00001};
        exp_data = '{30'h100, 30'h300, 30'h500, 30'h100};
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("t2_rc_ready_%0d", k), 32'(rc_ready), 32'(exp_rc[k]));
            tick();
            check($sformatf("t2_S_valid_%0d", k), 32'(valid_out[P_S]), 32'h1);
            check($sformatf("t2_S_data_%0d", k), 32'(data_out[P_S]), 32'(exp_data[k]));
        end
        clear_inputs();
        tick();
        check("t2_drained", 32'(valid_out), 32'h0);

        // 3: back-pressure on E
        ready_in[P_E] = 1'b0;
        send(P_N, DIR_E, 30'hAAA);
        #1;
        check("t3_rc_first", 32'(rc_ready[P_N]), 32'h1);
        tick();
        send(P_N, DIR_E, 30'hBBB);
        #1;
        check("t3_rc_held", 32'(rc_ready[P_N]), 32'h0);
        tick();
        check("t3_E_valid_held", 32'(valid_out[P_E]), 32'h1);
        check("t3_E_data_held", 32'(data_out[P_E]), 32'hAAA);
        ready_in[P_E] = 1'b1;
        #1;
        check("t3_rc_released", 32'(rc_ready[P_N]), 32'h1);
        tick();
        clear_inputs();
        check("t3_E_valid_swap", 32'(valid_out[P_E]), 32'h1);
        check("t3_E_data_swap", 32'(data_out[P_E]), 32'hBBB);
        tick();
        check("t3_drained", 32'(valid_out), 32'h0);

        // 4: malformed directions on W
        send(P_W, 5'b00000, 30'hDEAD);
        #1;
        check("t4_rc_zero_dir", 32'(rc_ready), 32'b00100);
        tick();
        clear_inputs();
        check("t4_err_zero_dir", 32'(err_dir), 32'h1);
        check("t4_valid_zero_dir", 32'(valid_out), 32'h0);
        tick();
        check("t4_err_clear1", 32'(err_dir), 32'h0);
        send(P_W, 5'b01100, 30'hBEEF);
        #1;
        check("t4_rc_multi_dir", 32'(rc_ready), 32'b00100);
        tick();
        clear_inputs();
        check("t4_err_multi_dir", 32'(err_dir), 32'h1);
        check("t4_valid_multi_dir", 32'(valid_out), 32'h0);
        tick();
        check("t4_err_clear2", 32'(err_dir), 32'h0);

        // 6: five disjoint routes in one cycle, outputs then held full
        ready_in = '0;
        send(P_N, DIR_E, 30'h1);
        send(P_E, DIR_W, 30'h2);
        send(P_W, DIR_S, 30'h3);
        send(P_S, DIR_L, 30'h4);
        send(P_L, DIR_N, 30'h5);
        #1;
        check("t6_rc_all", 32'(rc_ready), 32'b11111);
        tick();
        clear_inputs();
        check("t6_valid_all", 32'(valid_out), 32'b11111);
        check("t6_N_data", 32'(data_out[P_N]), 32'h5);
        check("t6_E_data", 32'(data_out[P_E]), 32'h1);
        check("t6_W_data", 32'(data_out[P_W]), 32'h2);
        check("t6_S_data", 32'(data_out[P_S]), 32'h3);
        check("t6_L_data", 32'(data_out[P_L]), 32'h4);
        tick();
        check("t6_valid_held", 32'(valid_out), 32'b11111);

        // 5: reset with every slot full; S pointer sits at S so only a reset
        // lets N beat L afterwards
        rst = 1'b1;
        ready_in[P_N] = 1'b1;
        send(P_N, DIR_N, 30'h77);
        #1;
        check("t5_rc_in_reset", 32'(rc_ready), 32'h0);
        tick();
        clear_inputs();
        ready_in = '0;
        check("t5_valid_cleared", 32'(valid_out), 32'h0);
        for (int o = 0; o < NPORT; o++) check($sformatf("t5_data_cleared%0d", o), 32'(data_out[o]), 32'h0);
        rst = 1'b0;
        ready_in[P_S] = 1'b1;
        send(P_N, DIR_S, 30'hA1);
        send(P_L, DIR_S, 30'hA5);
        #1;
        check("t5_post_reset_winner", 32'(rc_ready), 32'b00001);
        tick();
        clear_inputs();
        check("t5_S_data", 32'(data_out[P_S]), 32'hA1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
